pad_gpio_ctrl: RTL
==================

# pad_gpio_ctrl

Core-side controller for one bidirectional functional pad. Drives the pad's active-low output enable, output data and active-low pull enable. Brings the pad's input value back into the clock domain through a synchronizer, a programmable debounce filter and an edge detector. Sequences direction changes with an enforced hi-Z turnaround so the core and an external driver never contend. One instance sits between each GPIO register slice and its pad cell.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flop count on the pad input; must be at least 2.
- DEBOUNCE_W, 8, width of the debounce counter and limit.
- TURNAROUND, 2, hi-Z cycles inserted on every direction change; must be at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- dir_req_i  input  1  requested direction: 1 = output, 0 = input.
- out_val_i  input  1  value to drive while in output mode.
- od_en_i  input  1  open-drain mode: drive 0, release on 1.
- pull_en_i  input  1  enable the pad pull resistor.
- debounce_lim_i  input  DEBOUNCE_W  debounce limit L.
- pad_o_i  input  1  raw value from the pad input buffer; asynchronous.
- pad_oen_o  output  1  pad output enable, active-low.
- pad_i_o  output  1  pad output data.
- pad_pen_o  output  1  pad pull enable, active-low.
- in_val_o  output  1  debounced input value.
- rise_o  output  1  one-cycle pulse on a debounced 0→1 change.
- fall_o  output  1  one-cycle pulse on a debounced 1→0 change.
- busy_o  output  1  high while in either turnaround state.

## Operation
- All outputs are registered.
- Values after reset:
  - state = IN
  - pad_oen_o = 1, pad_i_o = 0, pad_pen_o = 1
  - all synchronizer flops = 0, in_val_o = 0
  - debounce counter = 0, turnaround counter = 0
  - rise_o = 0, fall_o = 0, busy_o = 0
- An assertion of rst_ni mid-turnaround or mid-drive returns to these values on the next edge.
- State machine (turnaround counter T):
  - IN, with dir_req_i = 1: go to T_OUT and load T = TURNAROUND-1.
  - T_OUT, with dir_req_i = 0: go to IN immediately.
  - T_OUT, with T = 0: go to OUT.
  - T_OUT, otherwise: decrement T.
  - OUT, with dir_req_i = 0: go to T_IN and load T = TURNAROUND-1.
  - T_IN, with dir_req_i = 1: go to T_OUT and load T = TURNAROUND-1.
  - T_IN, with T = 0: go to IN.
  - T_IN, otherwise: decrement T.
- Pad drive is registered from the next-state value, so it is aligned with the state:
  - IN, T_OUT, T_IN: pad_oen_o = 1.
  - OUT, push-pull (od_en_i = 0): pad_oen_o = 0, pad_i_o = out_val_i.
  - OUT, open-drain (od_en_i = 1): pad_i_o = 0, pad_oen_o = out_val_i.
  - pad_i_o keeps its last value whenever the pad is not driven.
  - pad_pen_o = ~pull_en_i in every state.
- Synchronizer: pad_o_i passes through SYNC_STAGES flops; the last flop is the synchronized value s.
- Debounce filter, counter C, evaluated every cycle in state IN or OUT:
  - s = in_val_o: C = 0.
  - s ≠ in_val_o and C = L: in_val_o becomes s, C = 0, and rise_o or fall_o pulses in that same cycle.
  - otherwise: C increments.
  - The counter saturates at L, so it never wraps.
  - L = 0 accepts a change after one cycle.
  - A change in L mid-count takes effect from the next comparison.
- In T_OUT and T_IN the filter is frozen:
  - C is forced to 0.
  - in_val_o holds its value.
  - rise_o and fall_o are held at 0.
  - The synchronizer keeps running.
- busy_o = 1 exactly when the state is T_OUT or T_IN.

## Timing
- Pad input to in_val_o: a stable new level on pad_o_i reaches s after SYNC_STAGES edges. in_val_o changes L+1 edges after that.
- With the default parameters and L = 0, total latency is 3 cycles.
- rise_o and fall_o appear in the same cycle as the in_val_o change.
- Drive path: a change on out_val_i or od_en_i in OUT appears on the pad outputs after 1 cycle.
- Entering output mode:
  - dir_req_i rises at edge t, in IN.
  - Edges t+1 through t+TURNAROUND: state = T_OUT, busy_o = 1, pad_oen_o = 1.
  - Edge t+TURNAROUND+1: state = OUT; pad_oen_o falls (push-pull) and busy_o falls.
- Leaving output mode:
  - dir_req_i falls at edge t, in OUT.
  - Edge t+1: pad_oen_o = 1 and busy_o = 1.
  - Edge t+TURNAROUND+1: state = IN and the filter resumes.
- Simultaneous events: a dir_req_i toggle in the same cycle as the last turnaround cycle (T = 0) follows the dir_req_i branch. No cycle is spent in the abandoned target state.

## Test plan
- Reset: hold rst_ni = 0 with pad_o_i = 1 for 3 cycles. Require pad_oen_o = 1, pad_pen_o = 1, in_val_o = 0, busy_o = 0. After release with L = 0, require in_val_o = 1 and a single rise_o pulse 3 cycles later.
- Debounce: L = 4; apply pulses on pad_o_i of 4 cycles then 5 cycles. The 4-cycle pulse is rejected. The 5-cycle pulse sets in_val_o = 1 exactly 2+5 cycles after its start, with one rise_o pulse.
- Turnaround: TURNAROUND = 2, out_val_i = 0.
  - Raise dir_req_i. Require busy_o = 1 for 2 cycles, then pad_oen_o = 0 and pad_i_o = 0.
  - Drop dir_req_i. Require pad_oen_o = 1 the next cycle and busy_o = 1 for 2 cycles.
- Open-drain: in OUT with od_en_i = 1, toggle out_val_i 1,0,1. Require pad_oen_o = 1,0,1 with pad_i_o = 0 throughout, each one cycle later. In push-pull, pad_i_o follows out_val_i.
- Aborted turnaround: raise dir_req_i, then drop it after 1 cycle in T_OUT. Require a return to IN with pad_oen_o never 0. Require no rise_o or fall_o while frozen, and C restarting from 0.
- Pull: toggle pull_en_i in each state. Require pad_pen_o = ~pull_en_i one cycle later, independent of state.

Source files
------------

// File: rtl/pad_gpio_ctrl.sv
// Core-side controller for one bidirectional pad: direction sequencing with
// hi-Z turnaround, pad drive, and a synchronized, debounced, edge-detected input.
module pad_gpio_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8,
    parameter int unsigned TURNAROUND  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dir_req_i,
    input  logic                  out_val_i,
    input  logic                  od_en_i,
    input  logic                  pull_en_i,
    input  logic [DEBOUNCE_W-1:0] debounce_lim_i,
    input  logic                  pad_o_i,
    output logic                  pad_oen_o,
    output logic                  pad_i_o,
    output logic                  pad_pen_o,
    output logic                  in_val_o,
    output logic                  rise_o,
    output logic                  fall_o,
    output logic                  busy_o
);

    localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(TURNAROUND - 1);

    localparam logic [1:0] ST_IN    = 2'd0;
    localparam logic [1:0] ST_T_OUT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;
    localparam logic [1:0] ST_T_IN  = 2'd3;

    logic [1:0]             state, state_nxt;
    logic [TW-1:0]          tcnt, tcnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [DEBOUNCE_W-1:0]  dcnt, dcnt_nxt;
    logic                   in_val_nxt, rise_nxt, fall_nxt;
    logic                   oen_nxt, pad_i_nxt, busy_nxt;

    assign s = sync[SYNC_STAGES-1];

    // Next-state, filter and registered-output logic
    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = tcnt;
        dcnt_nxt   = dcnt;
        in_val_nxt = in_val_o;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        oen_nxt    = 1'b1;
        pad_i_nxt  = pad_i_o;
        busy_nxt   = 1'b0;

        // A direction request always wins over turnaround expiry
        case (state)
            ST_IN: begin
                if (dir_req_i) begin
                    state_nxt = ST_T_OUT;
                    tcnt_nxt  = T_LOAD;
                end
            end
            ST_T_OUT: begin
                if (!dir_req_i) begin
                    state_nxt = ST_IN;
                end else if (tcnt == '0) begin
                    state_nxt = ST_OUT;
                end else begin
                    tcnt_nxt = tcnt - TW'(1);
                end
            end
            ST_OUT: begin
                if (!dir_req_i) begin
                    state_nxt = ST_T_IN;
                    tcnt_nxt  = T_LOAD;
                end
            end
            default: begin
                if (dir_req_i) begin
                    state_nxt = ST_T_OUT;
                    tcnt_nxt  = T_LOAD;
                end else if (tcnt == '0) begin
                    state_nxt = ST_IN;
                end else begin
                    tcnt_nxt = tcnt - TW'(1);
                end
            end
        endcase

        // Filter runs only in settled states; >= keeps acceptance sane if L drops below C
        if (state == ST_IN || state == ST_OUT) begin
            if (s == in_val_o) begin
                dcnt_nxt = '0;
            end else if (dcnt >= debounce_lim_i) begin
                in_val_nxt = s;
                dcnt_nxt   = '0;
                rise_nxt   = s;
                fall_nxt   = ~s;
            end else begin
                dcnt_nxt = dcnt + DEBOUNCE_W'(1);
            end
        end else begin
            dcnt_nxt = '0;
        end

        if (state_nxt == ST_OUT) begin
            if (od_en_i) begin
                oen_nxt   = out_val_i;
                pad_i_nxt = 1'b0;
            end else begin
                oen_nxt   = 1'b0;
                pad_i_nxt = out_val_i;
            end
        end

        busy_nxt = (state_nxt == ST_T_OUT) || (state_nxt == ST_T_IN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IN;
            tcnt      <= '0;
            sync      <= '0;
            dcnt      <= '0;
            in_val_o  <= 1'b0;
            rise_o    <= 1'b0;
            fall_o    <= 1'b0;
            pad_oen_o <= 1'b1;
            pad_i_o   <= 1'b0;
            pad_pen_o <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            sync      <= {sync[SYNC_STAGES-2:0], pad_o_i};
            dcnt      <= dcnt_nxt;
            in_val_o  <= in_val_nxt;
            rise_o    <= rise_nxt;
            fall_o    <= fall_nxt;
            pad_oen_o <= oen_nxt;
            pad_i_o   <= pad_i_nxt;
            pad_pen_o <= ~pull_en_i;
            busy_o    <= busy_nxt;
        end
    end

endmodule
